// File: rtl/bidir_port_bank.sv
// ---------------------------------------------------------------------------
// bidir_port_bank
//
// Arbitrates CHANNELS logical channels onto one shared WIDTH-bit inout bus.
// A write drives the latched channel data onto the bus for one cycle. A read
// captures the bus into that channel's rdata slice. Whenever the bus changes
// direction, TURN_CYCLES released cycles are inserted first.
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous active-high reset; aborts any operation in flight
//   req     request valid, sampled only while idle
//   req_wr  1 = write (drive bus), 0 = read (capture bus)
//   req_ch  target channel; out-of-range values drop the request
//   wdata   per-channel write data, channel n at [n*WIDTH +: WIDTH]
//   bus     shared tri-state bus, driven only while bus_oe = 1
//   bus_oe  bus drive enable (write transfer cycle only)
//   busy    high whenever an operation is in progress
//   rdata   per-channel capture registers, same packing as wdata
//   rvalid  one-cycle pulse on bit n when rdata channel n updates
//   done    one-cycle pulse after any completed operation
// ---------------------------------------------------------------------------
module bidir_port_bank #(
   parameter int WIDTH       = 8,
   parameter int CHANNELS    = 4,
   parameter int TURN_CYCLES = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req,
   input  logic                        req_wr,
   input  logic [$clog2(CHANNELS)-1:0] req_ch,
   input  logic [WIDTH*CHANNELS-1:0]   wdata,
   inout  wire  [WIDTH-1:0]            bus,
   output logic                        bus_oe,
   output logic                        busy,
   output logic [WIDTH*CHANNELS-1:0]   rdata,
   output logic [CHANNELS-1:0]         rvalid,
   output logic                        done
);

   localparam int CH_W  = $clog2(CHANNELS);
   localparam int CH_N  = 2 ** CH_W;
   localparam int CNT_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);
   localparam logic [CH_W:0]    CH_LIMIT  = (CH_W + 1)'(CHANNELS);

   typedef enum logic [1:0] {IDLE, TURN, XFER} state_t;

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic               dir_reg, dir_next;
   logic               op_wr_reg, op_wr_next;
   logic [CH_W-1:0]    ch_reg, ch_next;
   logic [WIDTH-1:0]   wr_reg, wr_next;
   logic               done_reg;

   logic               ch_valid;
   logic               accept;

   // wdata unpacked into a power-of-two array so every req_ch code indexes
   // a real entry; codes beyond CHANNELS read zero and are never accepted.
   logic [WIDTH-1:0]   wdata_arr [CH_N];

   generate
      for (genvar gi = 0; gi < CH_N; gi++) begin : g_wslice
         if (gi < CHANNELS) begin : g_used
            assign wdata_arr[gi] = wdata[gi*WIDTH +: WIDTH];
         end else begin : g_unused
            assign wdata_arr[gi] = '0;
         end
      end
   endgenerate

   assign ch_valid = ({1'b0, req_ch} < CH_LIMIT);
   assign accept   = (state_reg == IDLE) && req && ch_valid;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      dir_next   = dir_reg;
      op_wr_next = op_wr_reg;
      ch_next    = ch_reg;
      wr_next    = wr_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               op_wr_next = req_wr;
               ch_next    = req_ch;
               wr_next    = wdata_arr[req_ch];
               if (req_wr != dir_reg) begin
                  state_next = TURN;
                  cnt_next   = TURN_LOAD;
               end else begin
                  state_next = XFER;
                  dir_next   = req_wr;
               end
            end
         end
         TURN: begin
            if (cnt_reg == '0) begin
               state_next = XFER;
               dir_next   = op_wr_reg;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         XFER:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         dir_reg   <= 1'b0;
         op_wr_reg <= 1'b0;
         ch_reg    <= '0;
         wr_reg    <= '0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         dir_reg   <= dir_next;
         op_wr_reg <= op_wr_next;
         ch_reg    <= ch_next;
         wr_reg    <= wr_next;
         done_reg  <= (state_reg == XFER);
      end
   end

   // Per-channel capture; only the addressed channel moves on a read exit.
   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_rd
         logic [WIDTH-1:0] rdata_reg;
         logic             rvalid_reg;
         logic             cap;

         assign cap = (state_reg == XFER) && !op_wr_reg && (ch_reg == CH_W'(gi));

         always_ff @(posedge clk) begin
            if (rst) begin
               rdata_reg  <= '0;
               rvalid_reg <= 1'b0;
            end else begin
               rvalid_reg <= cap;
               if (cap) begin
                  rdata_reg <= bus;
               end
            end
         end

         assign rdata[gi*WIDTH +: WIDTH] = rdata_reg;
         assign rvalid[gi]               = rvalid_reg;
      end
   endgenerate

   assign busy   = (state_reg != IDLE);
   assign bus_oe = (state_reg == XFER) && op_wr_reg;
   assign bus    = bus_oe ? wr_reg : {WIDTH{1'bz}};
   assign done   = done_reg;

endmodule

// File: tb/tb_bidir_port_bank.sv
// ---------------------------------------------------------------------------
// tb_bidir_port_bank
//
// Directed bench for bidir_port_bank. Main instance: WIDTH=8, CHANNELS=4,
// TURN_CYCLES=2, with an external bus driver enabled only around reads.
// A second instance with CHANNELS=3 exercises the dropped out-of-range
// channel code. Inputs change and outputs are sampled 1 time unit after
// each rising edge.
// ---------------------------------------------------------------------------
module tb_bidir_port_bank;

   logic        clk = 1'b0;
   logic        rst;
   logic        req, req_wr;
   logic [1:0]  req_ch;
   logic [31:0] wdata;
   wire  [7:0]  bus;
   logic        bus_oe, busy, done;
   logic [31:0] rdata;
   logic [3:0]  rvalid;

   logic        ext_en;
   logic [7:0]  ext_val;
   assign bus = ext_en ? ext_val : 8'bz;

   logic        req3, req_wr3;
   logic [1:0]  req_ch3;
   logic [23:0] wdata3;
   wire  [7:0]  bus3;
   logic        bus_oe3, busy3, done3;
   logic [23:0] rdata3;
   logic [2:0]  rvalid3;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   bidir_port_bank #(.WIDTH(8), .CHANNELS(4), .TURN_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_ch(req_ch),
      .wdata(wdata), .bus(bus), .bus_oe(bus_oe), .busy(busy),
      .rdata(rdata), .rvalid(rvalid), .done(done)
   );

   bidir_port_bank #(.WIDTH(8), .CHANNELS(3), .TURN_CYCLES(2)) dut3 (
      .clk(clk), .rst(rst), .req(req3), .req_wr(req_wr3), .req_ch(req_ch3),
      .wdata(wdata3), .bus(bus3), .bus_oe(bus_oe3), .busy(busy3),
      .rdata(rdata3), .rvalid(rvalid3), .done(done3)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; req_wr = 1'b0; req_ch = 2'd0; wdata = '0;
      ext_en = 1'b0; ext_val = 8'h00;
      req3 = 1'b0; req_wr3 = 1'b0; req_ch3 = 2'd0; wdata3 = '0;

      // Reset held three cycles
      repeat (3) step();
      check("rst_busy",   32'(busy),   32'd0);
      check("rst_oe",     32'(bus_oe), 32'd0);
      check("rst_rdata",  rdata,       32'd0);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_done",   32'(done),   32'd0);
      rst = 1'b0;
      $display("reset: busy=%0d bus_oe=%0d rdata=%h", busy, bus_oe, rdata);

      // First write after reset: ch2 = A5, two TURN cycles first
      req = 1'b1; req_wr = 1'b1; req_ch = 2'd2; wdata = 32'h00A5_0000;
      step();                                   // E0 -> TURN
      check("w1_busy",     32'(busy),   32'd1);
      check("w1_turn0_oe", 32'(bus_oe), 32'd0);
      req = 1'b0; wdata = 32'hFFFF_FFFF;        // late wdata change must not matter
      step();                                   // E1 -> TURN
      check("w1_turn1_oe", 32'(bus_oe), 32'd0);
      step();                                   // E2 -> XFER
      check("w1_xfer_oe",   32'(bus_oe), 32'd1);
      check("w1_bus",       32'(bus),    32'h0000_00A5);
      check("w1_xfer_done", 32'(done),   32'd0);
      step();                                   // E3 -> done cycle
      check("w1_done",      32'(done),   32'd1);
      check("w1_done_busy", 32'(busy),   32'd0);
      check("w1_done_oe",   32'(bus_oe), 32'd0);
      step();
      check("w1_done_clr",  32'(done),   32'd0);
      $display("write ch2 A5 complete");

      // Same-direction write: ch1 = 3C, no TURN
      req = 1'b1; req_wr = 1'b1; req_ch = 2'd1; wdata = 32'h0000_3C00;
      step();
      check("w2_oe",  32'(bus_oe), 32'd1);
      check("w2_bus", 32'(bus),    32'h0000_003C);
      req = 1'b0;
      step();
      check("w2_done", 32'(done), 32'd1);
      $display("write ch1 3C complete");

      // Read after write: ch3 captures 5A after two TURN cycles
      ext_en = 1'b1; ext_val = 8'h5A;
      req = 1'b1; req_wr = 1'b0; req_ch = 2'd3;
      step();                                   // E0 -> TURN
      req = 1'b0;
      check("r1_turn_oe", 32'(bus_oe), 32'd0);
      check("r1_busy",    32'(busy),   32'd1);
      step(); step();                           // E2 -> XFER
      check("r1_xfer_oe",     32'(bus_oe), 32'd0);
      check("r1_xfer_rvalid", 32'(rvalid), 32'd0);
      step();                                   // E3 -> done cycle
      check("r1_done",   32'(done),   32'd1);
      check("r1_rvalid", 32'(rvalid), 32'b1000);
      check("r1_rdata",  rdata,       32'h5A00_0000);
      step();
      check("r1_rvalid_clr", 32'(rvalid), 32'd0);
      check("r1_rdata_hold", rdata,       32'h5A00_0000);
      ext_en = 1'b0;
      $display("read ch3 rdata=%h", rdata);

      // Write accepted into TURN, extra req during TURN, then reset abort
      req = 1'b1; req_wr = 1'b1; req_ch = 2'd0; wdata = 32'h0000_0077;
      step();                                   // E0 -> TURN
      req_wr = 1'b0; req_ch = 2'd1;             // ignored request seen at E1
      step();                                   // E1
      req = 1'b0;
      check("ab_busy", 32'(busy),   32'd1);
      check("ab_oe",   32'(bus_oe), 32'd0);
      rst = 1'b1;
      step();                                   // E2: reset edge
      rst = 1'b0;
      check("ab_busy_rst", 32'(busy),   32'd0);
      check("ab_oe_rst",   32'(bus_oe), 32'd0);
      check("ab_done",     32'(done),   32'd0);
      step();
      check("ab_done_after", 32'(done),   32'd0);
      check("ab_oe_after",   32'(bus_oe), 32'd0);
      check("ab_rvalid",     32'(rvalid), 32'd0);
      check("ab_rdata",      rdata,       32'd0);
      $display("abort: busy=%0d done=%0d", busy, done);

      // Read after abort: dir back to 0, so no TURN
      ext_en = 1'b1; ext_val = 8'h11;
      req = 1'b1; req_wr = 1'b0; req_ch = 2'd1;
      step();
      req = 1'b0;
      check("r2_busy", 32'(busy),   32'd1);
      check("r2_oe",   32'(bus_oe), 32'd0);
      step();
      check("r2_done",   32'(done),   32'd1);
      check("r2_rvalid", 32'(rvalid), 32'b0010);
      check("r2_rdata",  rdata,       32'h0000_1100);
      ext_en = 1'b0;
      $display("read ch1 rdata=%h", rdata);

      // Held request with alternating direction
      req = 1'b1; req_wr = 1'b1; req_ch = 2'd2; wdata = 32'h00C3_0000;
      step();                                   // E0 -> TURN
      check("h1_busy", 32'(busy),   32'd1);
      check("h1_oe",   32'(bus_oe), 32'd0);
      step(); step();                           // E2 -> XFER
      check("h1_xfer_oe", 32'(bus_oe), 32'd1);
      check("h1_bus",     32'(bus),    32'h0000_00C3);
      step();                                   // E3 -> done cycle
      check("h1_done",      32'(done), 32'd1);
      check("h1_done_busy", 32'(busy), 32'd0);
      req_wr = 1'b0; req_ch = 2'd0; ext_en = 1'b1; ext_val = 8'h99;
      step();                                   // E4: accepted in done cycle
      check("h2_busy", 32'(busy),   32'd1);
      check("h2_oe",   32'(bus_oe), 32'd0);
      check("h2_done", 32'(done),   32'd0);
      step(); step();                           // E6 -> read XFER
      check("h2_xfer_oe", 32'(bus_oe), 32'd0);
      step();                                   // E7 -> done cycle
      check("h2_done2",  32'(done),   32'd1);
      check("h2_rvalid", 32'(rvalid), 32'b0001);
      check("h2_rdata",  rdata,       32'h0000_1199);
      req = 1'b0; ext_en = 1'b0;
      step();
      check("h2_idle", 32'(busy), 32'd0);
      $display("held req sequence rdata=%h", rdata);

      // CHANNELS=3 instance: channel code 3 is dropped
      req3 = 1'b1; req_wr3 = 1'b1; req_ch3 = 2'd3; wdata3 = 24'h42_0000;
      step();
      check("inv_busy", 32'(busy3),   32'd0);
      check("inv_oe",   32'(bus_oe3), 32'd0);
      step();
      check("inv_busy2", 32'(busy3), 32'd0);
      check("inv_done",  32'(done3), 32'd0);
      req_ch3 = 2'd2;
      step();                                   // accepted -> TURN
      req3 = 1'b0;
      check("v3_busy", 32'(busy3), 32'd1);
      step(); step();                           // XFER
      check("v3_oe",  32'(bus_oe3), 32'd1);
      check("v3_bus", 32'(bus3),    32'h0000_0042);
      $display("channels=3: invalid code dropped, ch2 write bus=%h", bus3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
